// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single write port of the register file.
// The ALU path has absolute priority and is never stalled. Load/long-op results
// are buffered in a DEPTH-entry FIFO and drain into slots where the ALU is idle.
// Writes addressed to register 0 are suppressed, but they still consume their slot.
// All write-port outputs come straight from flops.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a load that arrives
// while the ALU is idle and the FIFO is empty goes straight to the output registers.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   writeEnable,
    output logic [ADDR_W-1:0]      writeAddr,
    output logic [DATA_W-1:0]      writeData,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_ld_ready;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_nxt_we;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [DATA_W-1:0] w_nxt_data;

    // Handshake and FIFO control, derived only from the registered occupancy
    always_comb begin
        w_ld_ready = (r_count < CNT_W'(DEPTH));
        w_empty    = (r_count == {CNT_W{1'b0}});
        w_accept   = ld_valid && w_ld_ready;
        w_pop      = !alu_valid && !w_empty;
`ifdef WB_BYPASS_EN
        w_bypass   = !alu_valid && w_empty && w_accept;
`else
        w_bypass   = 1'b0;
`endif
        w_push     = w_accept && !w_bypass;
    end

    // Source select (ALU > FIFO head > bypassed load) and the register-0 filter
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = {ADDR_W{1'b0}};
        w_sel_data  = {DATA_W{1'b0}};
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = alu_addr;
            w_sel_data  = alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_mem_addr[r_rd_ptr];
            w_sel_data  = r_mem_data[r_rd_ptr];
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = ld_addr;
            w_sel_data  = ld_data;
        end else begin
            w_sel_valid = 1'b0;
        end

        w_nxt_we = w_sel_valid && (w_sel_addr != {ADDR_W{1'b0}});
        if (w_nxt_we) begin
            w_nxt_addr = w_sel_addr;
            w_nxt_data = w_sel_data;
        end else begin
            w_nxt_addr = {ADDR_W{1'b0}};
            w_nxt_data = {DATA_W{1'b0}};
        end
    end

    // FIFO storage; entries are only ever read after being written, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= ld_addr;
            r_mem_data[r_wr_ptr] <= ld_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
        end else begin
            r_we    <= w_nxt_we;
            r_waddr <= w_nxt_addr;
            r_wdata <= w_nxt_data;
        end
    end

    assign ld_ready    = w_ld_ready;
    assign writeEnable = r_we;
    assign writeAddr   = r_waddr;
    assign writeData   = r_wdata;
    assign fifo_count  = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with a queue-based scoreboard of pending loads.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [2:0]  fifo_count;

    int checks = 0;
    int passes = 0;

    logic [36:0] mq [$];
    logic [4:0]  nxt_a;
    logic [31:0] nxt_d;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock of stimulus; the scoreboard predicts the write this edge produces.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv);
        logic        exp_rdy;
        logic        acc;
        logic        byp;
        logic        have;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [36:0] ent;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = nxt_a;
        ld_data   = nxt_d;
        exp_rdy = (mq.size() < DEPTH);
        check("ld_ready", {63'd0, ld_ready}, {63'd0, exp_rdy});
        acc  = lv && exp_rdy;
        byp  = 1'b0;
        have = 1'b0;
        ea   = 5'd0;
        ed   = 32'd0;
        if (av) begin
            have = 1'b1; ea = aa; ed = ad;
        end else if (mq.size() > 0) begin
            ent = mq.pop_front();
            have = 1'b1; ea = ent[36:32]; ed = ent[31:0];
        end else if (BYP && acc) begin
            have = 1'b1; byp = 1'b1; ea = nxt_a; ed = nxt_d;
        end
        if (acc && !byp) mq.push_back({nxt_a, nxt_d});
        if (acc) begin
            nxt_a = nxt_a + 5'd1;
            nxt_d = nxt_d + 32'h0000_0111;
        end
        if (!have || ea == 5'd0) begin
            have = 1'b0; ea = 5'd0; ed = 32'd0;
        end
        @(posedge clk); #1;
        check("writeEnable", {63'd0, writeEnable}, {63'd0, have});
        check("writeAddr",   {59'd0, writeAddr},   {59'd0, ea});
        check("writeData",   {32'd0, writeData},   {32'd0, ed});
        check("fifo_count",  {61'd0, fifo_count},  64'(mq.size()));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},    {63'd0, writeEnable}, 64'd0);
        check({tag, "_addr"},  {59'd0, writeAddr},   64'd0);
        check({tag, "_data"},  {32'd0, writeData},   64'd0);
        check({tag, "_count"}, {61'd0, fifo_count},  64'd0);
        check({tag, "_rdy"},   {63'd0, ld_ready},    64'd1);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
        nxt_a = 5'd1; nxt_d = 32'h0000_1000;
        @(posedge clk); @(posedge clk); #1;
        check_zero("por");
        reset = 1'b0;

        // Reset mid-drain with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 5'd1, 32'h0000_0055, 1'b1);
        check("fill3_count", {61'd0, fifo_count}, 64'd3);
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk); #1;
        void'(mq.pop_front());
        #3 reset = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_held");
        mq.delete();
        reset = 1'b0;
        step(1'b0, 5'd0, 32'd0, 1'b0);
        check_zero("rst_after");

        // Lone ALU write followed by an idle slot
        step(1'b1, 5'd5, 32'h0000_00AA, 1'b0);
        check("alu_addr5", {59'd0, writeAddr}, 64'd5);
        step(1'b0, 5'd0, 32'd0, 1'b0);

        // ALU busy for 6 cycles while loads 7.. back up and fill the FIFO
        nxt_a = 5'd7; nxt_d = 32'h0000_7000;
        for (int i = 0; i < 6; i++) step(1'b1, 5'(20 + i), 32'h0000_00A0 + 32'(i), 1'b1);
        check("full_count", {61'd0, fifo_count}, 64'd4);
        check("full_rdy",   {63'd0, ld_ready},   64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0);
            check("drain_order", {59'd0, writeAddr}, 64'(7 + i));
        end
        step(1'b0, 5'd0, 32'd0, 1'b0);

        // Register-0 writes from both sources are suppressed; the FIFO still pops
        step(1'b1, 5'd0, 32'h0000_00FF, 1'b0);
        nxt_a = 5'd0; nxt_d = 32'hDEAD_BEEF;
        step(1'b1, 5'd2, 32'h0000_0022, 1'b1);
        check("r0_queued", {61'd0, fifo_count}, 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0);
        check("r0_popped", {61'd0, fifo_count}, 64'd0);

        // Single load with idle ALU: latency depends on bypass
        nxt_a = 5'd3; nxt_d = 32'h0000_1234;
        step(1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0);

        // Steady push+pop at count 2 across pointer wrap
        nxt_a = 5'd11; nxt_d = 32'h0000_B000;
        step(1'b1, 5'd1, 32'h0000_0001, 1'b1);
        step(1'b1, 5'd1, 32'h0000_0002, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            check("pp_count", {61'd0, fifo_count}, 64'd2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
